// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR: one shared MAC stepped across NTAPS taps
// Coefficients are writable only while idle; the result saturates to OUT_W on a valid/ready port.
module fir_mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 3,
  parameter int OUT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       cfg_we,
  input  logic [$clog2(NTAPS)-1:0]   cfg_addr,
  input  logic signed [COEF_W-1:0]   cfg_data,
  output logic                       cfg_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       busy
);

  localparam int AW     = $clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  x [NTAPS];
  logic signed [COEF_W-1:0]  c [NTAPS];
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [PROD_W-1:0]  prod;
  logic signed [OUT_W-1:0]   sat_out;
  logic [AW-1:0]             tap;
  logic                      cfg_ok;

  function automatic logic signed [COEF_W-1:0] coef_default(input int k);
    case (k)
      0:       return -COEF_W'(1);
      1:       return COEF_W'(2);
      2:       return COEF_W'(3);
      default: return '0;
    endcase
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign cfg_ok   = (state == IDLE) && ({1'b0, cfg_addr} < (AW+1)'(NTAPS));

  // acc_next already includes the current tap, so the last MAC cycle can saturate it directly.
  always_comb begin
    prod     = x[tap] * c[tap];
    acc_next = acc + ACC_W'(prod);
    sat_out  = acc_next[OUT_W-1:0];
    if (acc_next > SAT_MAX)
      sat_out = SAT_MAX[OUT_W-1:0];
    else if (acc_next < SAT_MIN)
      sat_out = SAT_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      tap       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        x[k] <= '0;
        c[k] <= coef_default(k);
      end
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok)
        c[cfg_addr] <= cfg_data;

      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 1; k < NTAPS; k++)
              x[k] <= x[k-1];
            x[0]  <= in_data;
            acc   <= '0;
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          tap <= tap + 1'b1;
          if (tap == AW'(NTAPS-1)) begin
            out_data  <= sat_out;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - randomized and directed bench for fir_mac_sequencer against a behavioural model
module tb_fir_mac_sequencer;

  localparam int NT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_addr = '0;
  logic signed [7:0] cfg_data = '0;
  logic              cfg_err;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [15:0] out_data;
  logic              busy;

  int tests = 0;
  int fails = 0;

  fir_mac_sequencer #(.DATA_W(8), .COEF_W(8), .NTAPS(NT), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: a sample's result is the saturated dot product of history and coefficients,
  // shown NT cycles after acceptance and held until taken.
  int  m_x [NT];
  int  m_c [NT];
  bit  m_hold;
  int  m_cnt;
  int  m_res;
  int  m_out;
  bit  m_err;
  bit  m_idle_pre;

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NT; k++) m_x[k] = 0;
    m_c[0] = -1; m_c[1] = 2; m_c[2] = 3;
    m_hold = 0; m_cnt = 0; m_res = 0; m_out = 0; m_err = 0;
  endfunction

  function automatic int dot();
    longint s = 0;
    for (int k = 0; k < NT; k++) s += longint'(m_x[k]) * longint'(m_c[k]);
    return sat16(s);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_idle_pre = !m_hold && (m_cnt == 0);
      m_err = 0;
      if (cfg_we) begin
        if (m_idle_pre && cfg_addr < NT) m_c[cfg_addr] = int'(cfg_data);
        else m_err = 1;
      end
      if (m_hold && out_ready) m_hold = 0;
      if (m_idle_pre && in_valid) begin
        for (int k = NT-1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = int'(in_data);
        m_res = dot();
        m_cnt = NT;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hold = 1;
          m_out = m_res;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(!m_hold && m_cnt == 0));
    chk("busy", int'(busy), int'(m_hold || m_cnt != 0));
    chk("out_valid", int'(out_valid), int'(m_hold));
    if (m_hold) chk("out_data", int'(out_data), m_out);
    chk("cfg_err", int'(cfg_err), int'(m_err));
  end

  task automatic send(input int d);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("send_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 8'(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("valid_seen", int'(out_valid), 1);
  endtask

  task automatic get(output int v, output int lat);
    wait_valid(lat);
    v = int'(out_data);
    @(negedge clk);
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 2'(a);
    cfg_data = 8'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  int imp_in  [4] = '{1, 0, 0, 0};
  int imp_exp [4] = '{-1, 2, 3, 0};
  int ramp_in [3] = '{10, 20, 30};
  int ramp_exp[3] = '{-10, 0, 40};
  int sat_exp [3] = '{-16256, -32512, -32768};
  int nsat_exp[3] = '{16384, 32767, 32767};

  initial begin
    int v, lat, held;
    repeat (2) @(negedge clk);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send(imp_in[i]);
      get(v, lat);
      chk("impulse", v, imp_exp[i]);
      chk("impulse_lat", lat, 3);
    end
    for (int i = 0; i < 3; i++) begin
      send(ramp_in[i]);
      get(v, lat);
      chk("ramp", v, ramp_exp[i]);
    end

    // history is now 30,20,10; sample 5 gives -5+60+60
    out_ready = 1'b0;
    send(5);
    wait_valid(lat);
    held = int'(out_data);
    chk("bp_value", held, 115);
    in_valid = 1'b1;
    in_data  = 8'sd7;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), held);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", int'(in_ready), 1);
    chk("bp_released", int'(out_valid), 0);
    send(0);
    get(v, lat);
    chk("bp_not_accepted", v, 100);

    do_reset();
    for (int a = 0; a < 3; a++) cfg_write(a, 127);
    for (int i = 0; i < 3; i++) begin
      send(-128);
      get(v, lat);
      chk("sat_neg", v, sat_exp[i]);
    end
    do_reset();
    for (int a = 0; a < 3; a++) cfg_write(a, -128);
    for (int i = 0; i < 3; i++) begin
      send(-128);
      get(v, lat);
      chk("sat_pos", v, nsat_exp[i]);
    end

    do_reset();
    send(1);
    cfg_write(1, 5);
    chk("cfg_mac_err", int'(cfg_err), 1);
    @(negedge clk);
    chk("cfg_mac_err_end", int'(cfg_err), 0);
    get(v, lat);
    chk("cfg_mac_r0", v, -1);
    send(0);
    get(v, lat);
    chk("cfg_mac_c1_kept", v, 2);
    cfg_write(3, 9);
    chk("cfg_addr_err", int'(cfg_err), 1);
    @(negedge clk);
    chk("cfg_addr_err_end", int'(cfg_err), 0);

    do_reset();
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'sd4;
    in_valid = 1'b1; in_data = 8'sd1;
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    get(v, lat);
    chk("cfg_same_edge", v, 4);

    do_reset();
    cfg_write(2, 50);
    send(1);
    send(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(1);
    get(v, lat);
    chk("midrst_defaults", v, -1);
    send(0);
    send(0);
    get(v, lat);
    chk("midrst_c2_default", v, 3);

    repeat (3000) begin
      @(negedge clk);
      in_valid  = ($urandom % 2) == 0;
      in_data   = 8'($urandom);
      out_ready = ($urandom % 4) != 0;
      cfg_we    = ($urandom % 8) == 0;
      cfg_addr  = 2'($urandom);
      cfg_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR filter controller. It accepts one signed sample per input handshake, shifts it into an NTAPS-deep delay line, and sequences a single shared multiplier-accumulator over all taps, one tap per cycle. It presents the saturated result on a valid/ready output port. Coefficients sit in a small register file that is writable only while the sequencer is idle, so one MAC is shared across taps instead of instantiating NTAPS multipliers.

## Interface
- DATA_W, 8, sample width, signed
- COEF_W, 8, coefficient width, signed
- NTAPS, 3, number of taps (≥2)
- OUT_W, 16, output width, signed; result saturates to this width
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- in_valid  in  1  sample offered
- in_ready  out  1  sequencer can accept a sample
- in_data  in  DATA_W  signed sample
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  $clog2(NTAPS)  coefficient index
- cfg_data  in  COEF_W  signed coefficient value
- cfg_err  out  1  one-cycle pulse: rejected write
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  OUT_W  signed saturated result
- busy  out  1  high in MAC or HOLD

## Operation
- Storage:
  - Delay line x[0..NTAPS-1], x[0] newest.
  - Coefficients c[0..NTAPS-1].
  - Internal accumulator, ACC_W = DATA_W+COEF_W+$clog2(NTAPS) bits, signed.
  - Tap counter.
- Reset values:
  - State IDLE; x[] all 0.
  - Coefficients default to c[0]=-1, c[1]=2, c[2]=3; taps ≥3 reset to 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, cfg_err=0, busy=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: x[k]<=x[k-1], x[0]<=in_data, acc<=0, tap<=0, go to MAC.
- MAC:
  - Each cycle: acc <= acc + x[tap]*c[tap], with a full-precision signed product; tap++.
  - On the cycle with tap==NTAPS-1, go to HOLD and register out_data <= sat(final acc) and out_valid<=1.
  - in_ready=0.
- HOLD:
  - out_valid=1; out_data stable until handshake.
  - On out_valid&out_ready, return to IDLE with out_valid<=0.
  - in_ready=0.
- Saturation: a final acc greater than 2^(OUT_W-1)-1 clamps to the maximum; less than -2^(OUT_W-1) clamps to the minimum.
- Config writes:
  - Accepted only in IDLE with cfg_addr<NTAPS: c[cfg_addr]<=cfg_data.
  - A write in MAC/HOLD, or with cfg_addr≥NTAPS, is dropped and cfg_err pulses high for the next cycle.
- Simultaneous cfg_we and input acceptance in IDLE: the write lands at the same edge, so the MAC for that sample uses the new coefficient.
- Reset mid-operation: rst_n low aborts immediately to reset values; the partial result is discarded and the delay line is cleared.
- No tap wrap issue: the tap counter is only used in MAC and is reloaded to 0 on every acceptance.

## Timing
- Acceptance at edge E0; MAC at edges E1..E_NTAPS.
- out_valid is visible after edge E_NTAPS, i.e. NTAPS cycles after acceptance (3 by default).
- With out_ready held high, the HOLD handshake takes 1 cycle and IDLE takes 1 cycle.
- Maximum throughput is one sample per NTAPS+2 cycles (5 by default).
- in_ready is combinational from state only (high iff IDLE); it never depends on in_valid.
- out_valid, once high, stays high with constant out_data until out_ready is sampled high.
- cfg_err is a registered pulse, exactly 1 cycle per rejected write.

## Test plan
- Impulse with default coefficients: samples 1,0,0,0 -> out_data sequence -1, 2, 3, 0; each out_valid arrives exactly 3 cycles after its acceptance edge.
- Ramp: samples 10, 20, 30 -> outputs -10, 0, 40 (-30+40+30).
- Saturation: write c[0..2]=127, then samples -128,-128,-128 -> outputs -16256, -32512, -32768 (clamped from -48768). Repeat with c[]=-128 -> third output 32767.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid and out_data are held, in_ready=0, an offered sample is not accepted. Release -> handshake, then IDLE on the next cycle.
- Config rules:
  - Write c[1]=5 during MAC -> cfg_err is a 1-cycle pulse and c[1] is unchanged.
  - Write with cfg_addr=3 in IDLE -> cfg_err pulses.
  - cfg_we c[0]=4 in the same cycle as sample 1 accepted from a clear state -> output 4.
- Reset mid-MAC: drop rst_n one cycle after acceptance -> out_valid=0, in_ready=1 immediately. After release, sample 1 -> output -1, proving the delay line and coefficients are at defaults.
